qspi_read_streamer: RTL and testbench
=====================================

// Module: qspi_read_streamer
// PURPOSE
//  Upstream sequencer for the QSPI master. Accepts a read request (start byte address, word count),
//  splits it into bursts of at most MAX_BURST words and drives the master's command/control inputs.
//  Collects burst read data into a FWFT FIFO and presents it as a valid/ready 32-bit stream.
//  Issues a burst only when the FIFO can absorb the whole burst; the master itself cannot stall.
// PARAMETERS
//  FIFO_DEPTH  16        words in read FIFO (power of 2, >= MAX_BURST)
//  MAX_BURST   8         max words per master burst (>= 1)
//  READ_CMD    8'hEB     flash command byte (quad fast read)
//  DIVIDER     16'd4     sclk divider passed to master
//  SPI_MODE    2'b10     lane mode passed to master (2'b10 = quad)
//  CPOL/CPHA   0/0       clock polarity/phase passed to master
// PORTS
//  clk                      in   1   system clock
//  reset                    in   1   synchronous, active-high reset
//  req_valid / req_ready    in/out 1 request handshake; transfer on valid&&ready
//  req_addr                 in   24  start byte address
//  req_words                in   16  number of 32-bit words to read
//  out_valid / out_ready    out/in 1 read-data stream handshake
//  out_data                 out  32  FIFO head word
//  rd_busy                  out  1   request in progress
//  rd_done                  out  1   one-cycle pulse: last burst of request completed
//  rd_err                   out  1   sticky protocol error, cleared on next accepted request
//  m_enable                 out  1   start pulse to master
//  m_command/m_addr         out  8/24 command byte, burst start address
//  m_rw                     out  1   1 = read (constant 1)
//  m_data                   out  32  write data (constant 0)
//  m_burst_enable           out  1   constant 1
//  m_burst_count            out  16  words in current burst
//  m_divider/m_cpol/m_cpha/m_mode  out 16/1/1/2  static config from parameters
//  m_busy/m_done            in   1   master status; m_done is a one-cycle pulse
//  m_read_word              in   32  burst read data
//  m_burst_read_data_valid  in   1   m_read_word valid this cycle
// BEHAVIOUR
//  Reset: state IDLE, FIFO empty; req_ready=1, out_valid=0, out_data=0, rd_busy=0, rd_done=0,
//   rd_err=0, m_enable=0, m_addr=0, m_burst_count=0, m_command=READ_CMD.
//  FSM IDLE -> WAIT_SPACE -> ISSUE -> XFER -> (WAIT_SPACE | IDLE).
//  IDLE: req_ready=1. On accept latch addr/remaining, clear rd_err. req_words==0: no master
//   activity, rd_done pulses next cycle, stay IDLE.
//  WAIT_SPACE: chunk = min(remaining, MAX_BURST); advance when free slots >= chunk
//   (free counted after this cycle's pop).
//  ISSUE: m_enable=1 for exactly one cycle; m_addr/m_burst_count valid same cycle and held until m_done.
//  XFER: each m_burst_read_data_valid pushes m_read_word; rcv counter increments. On m_done:
//   rcv != chunk -> set rd_err; addr += 4*chunk (mod 2^24, wraps); remaining -= chunk;
//   remaining==0 -> rd_done pulse, IDLE; else WAIT_SPACE.
//  Valid beats beyond chunk or outside XFER: dropped, set rd_err. Push into full FIFO impossible
//   by construction; assert.
//  m_busy ignored for sequencing (m_done is authoritative); rd_busy = (state != IDLE).
//  FIFO: FWFT; word pushed in cycle N appears on out_data in N+1. Push and pop in same cycle
//   allowed at any fill level, including full (count unchanged) and empty-with-push (no bypass).
//  rd_done does not wait for FIFO drain; next request may start while FIFO still holds data.
//  Reset mid-burst: FSM to IDLE, FIFO flushed, m_enable low; master is reset by the same reset.
// STRUCTURE
//  qspi_pkg: state enum, QSPI command constants (READ_CMD values), mode encodings (single/dual/quad).
//  Sub-module qspi_rd_fifo: sync FWFT FIFO, params WIDTH/DEPTH, ports push/pop/full/empty/free_count.
//  Top: FSM, address/remaining/rcv counters, chunk calc, static master config.
// TESTING
//  Req addr 24'h000100, words 20, out_ready=1 -> bursts 8,8,4 at 0x100,0x120,0x140; 20 words in order;
//   one rd_done.
//  Same req, out_ready=0 -> exactly 2 bursts issued (16 words), third waits until 4 words popped.
//  Req addr 24'hFFFFF8, words 16 -> 2nd burst m_addr = 24'h000018 (wrap).
//  req_words=0 -> no m_enable, rd_done pulse one cycle after accept.
//  Model returns 7 beats for burst of 8 -> rd_err=1 after m_done; cleared on next accept.
//  Reset asserted mid-XFER -> next cycle req_ready=1, out_valid=0, m_enable=0.

Source files
------------

// File: rtl/qspi_read_streamer_pkg.sv
// Shared types and constants for the QSPI read streamer: sequencer states,
// flash read opcodes and lane-mode encodings.
package qspi_read_streamer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_SPACE = 2'd1,
        ST_ISSUE      = 2'd2,
        ST_XFER       = 2'd3
    } state_t;

    localparam logic [7:0] CMD_READ            = 8'h03;
    localparam logic [7:0] CMD_FAST_READ       = 8'h0B;
    localparam logic [7:0] CMD_DUAL_FAST_READ  = 8'hBB;
    localparam logic [7:0] CMD_QUAD_FAST_READ  = 8'hEB;

    localparam logic [1:0] MODE_SINGLE = 2'b00;
    localparam logic [1:0] MODE_DUAL   = 2'b01;
    localparam logic [1:0] MODE_QUAD   = 2'b10;

    function automatic logic [15:0] min_words(input logic [15:0] a, input logic [15:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/qspi_read_streamer_if.sv
// Command/status bus between the read streamer (master modport) and the
// QSPI master core it sequences (slave modport).
interface qspi_read_streamer_if;
    logic        m_enable;
    logic [7:0]  m_command;
    logic [23:0] m_addr;
    logic        m_rw;
    logic [31:0] m_data;
    logic        m_burst_enable;
    logic [15:0] m_burst_count;
    logic [15:0] m_divider;
    logic        m_cpol;
    logic        m_cpha;
    logic [1:0]  m_mode;
    logic        m_busy;
    logic        m_done;
    logic [31:0] m_read_word;
    logic        m_burst_read_data_valid;

    modport master (
        output m_enable, m_command, m_addr, m_rw, m_data, m_burst_enable,
               m_burst_count, m_divider, m_cpol, m_cpha, m_mode,
        input  m_busy, m_done, m_read_word, m_burst_read_data_valid
    );

    modport slave (
        input  m_enable, m_command, m_addr, m_rw, m_data, m_burst_enable,
               m_burst_count, m_divider, m_cpol, m_cpha, m_mode,
        output m_busy, m_done, m_read_word, m_burst_read_data_valid
    );
endinterface

// File: rtl/qspi_read_streamer_rd_fifo.sv
// Synchronous first-word-fall-through FIFO: a word pushed in one cycle is on
// dout the next; push+pop together is legal at any fill level.
module qspi_rd_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] free_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign empty      = (r_count == '0);
    assign full       = (r_count == CW'(DEPTH));
    assign free_count = CW'(DEPTH) - r_count;

    // No bypass: a pop against an empty FIFO is ignored even if a push lands.
    assign w_pop  = pop && !empty;
    assign w_push = push && (!full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    assign dout = empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/qspi_read_streamer.sv
// Splits a word read request into bursts for the QSPI master, issuing each
// burst only when the read FIFO can absorb all of it, and streams the data out.
module qspi_read_streamer
    import qspi_read_streamer_pkg::*;
#(
    parameter int          FIFO_DEPTH = 16,
    parameter int          MAX_BURST  = 8,
    parameter logic [7:0]  READ_CMD   = CMD_QUAD_FAST_READ,
    parameter logic [15:0] DIVIDER    = 16'd4,
    parameter logic [1:0]  SPI_MODE   = MODE_QUAD,
    parameter logic        CPOL       = 1'b0,
    parameter logic        CPHA       = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [23:0] req_addr,
    input  logic [15:0] req_words,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        rd_busy,
    output logic        rd_done,
    output logic        rd_err,
    qspi_read_streamer_if.master qm
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t        r_state;
    state_t        w_state_next;
    logic [23:0]   r_addr;
    logic [15:0]   r_remaining;
    logic [15:0]   r_chunk;
    logic [15:0]   r_rcv;
    logic          r_done;
    logic          r_err;

    logic          w_accept;
    logic          w_enable;
    logic [15:0]   w_chunk;
    logic          w_pop;
    logic [CW-1:0] w_free;
    logic [15:0]   w_free_after;
    logic          w_space_ok;
    logic          w_beat_ok;
    logic          w_beat_bad;
    logic [15:0]   w_rcv_next;
    logic          w_burst_end;
    logic          w_last_burst;
    logic          w_fifo_full;
    logic          w_fifo_empty;
    logic          w_unused_busy;

    assign w_accept     = req_valid && (r_state == ST_IDLE);
    assign w_chunk      = min_words(r_remaining, 16'(MAX_BURST));
    assign w_pop        = out_ready && !w_fifo_empty;
    // Space check counts the slot freed by this cycle's pop.
    assign w_free_after = 16'(w_free) + 16'(w_pop);
    assign w_space_ok   = (w_free_after >= w_chunk);
    assign w_beat_ok    = qm.m_burst_read_data_valid && (r_state == ST_XFER) && (r_rcv < r_chunk);
    assign w_beat_bad   = qm.m_burst_read_data_valid && !w_beat_ok;
    assign w_rcv_next   = r_rcv + 16'(w_beat_ok);
    assign w_burst_end  = (r_state == ST_XFER) && qm.m_done;
    assign w_last_burst = (r_remaining == r_chunk);
    // Sequencing keys off m_done alone; busy is informational.
    assign w_unused_busy = qm.m_busy;

    always_comb begin
        w_state_next = r_state;
        w_enable     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && (req_words != 16'd0)) begin
                    w_state_next = ST_WAIT_SPACE;
                end
            end
            ST_WAIT_SPACE: begin
                if (w_space_ok) begin
                    w_state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_enable     = 1'b1;
                w_state_next = ST_XFER;
            end
            ST_XFER: begin
                if (qm.m_done) begin
                    w_state_next = w_last_burst ? ST_IDLE : ST_WAIT_SPACE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_chunk     <= '0;
            r_rcv       <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= (w_accept && (req_words == 16'd0)) || (w_burst_end && w_last_burst);
            if (w_accept) begin
                r_addr      <= req_addr;
                r_remaining <= req_words;
            end
            if ((r_state == ST_WAIT_SPACE) && w_space_ok) begin
                r_chunk <= w_chunk;
                r_rcv   <= '0;
            end
            if (r_state == ST_XFER) begin
                r_rcv <= w_rcv_next;
            end
            if (w_burst_end) begin
                r_addr      <= r_addr + 24'({r_chunk, 2'b00});
                r_remaining <= r_remaining - r_chunk;
            end
            // A fresh request clears the error unless it is re-flagged this cycle.
            if (w_accept) begin
                r_err <= 1'b0;
            end
            if (w_beat_bad || (w_burst_end && (w_rcv_next != r_chunk))) begin
                r_err <= 1'b1;
            end
        end
    end

    qspi_rd_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (w_beat_ok),
        .din        (qm.m_read_word),
        .pop        (out_ready),
        .dout       (out_data),
        .full       (w_fifo_full),
        .empty      (w_fifo_empty),
        .free_count (w_free)
    );

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(w_beat_ok && w_fifo_full && !w_pop));

    assign req_ready = (r_state == ST_IDLE);
    assign rd_busy   = (r_state != ST_IDLE);
    assign rd_done   = r_done;
    assign rd_err    = r_err;
    assign out_valid = !w_fifo_empty;

    assign qm.m_enable       = w_enable;
    assign qm.m_command      = READ_CMD;
    assign qm.m_addr         = r_addr;
    assign qm.m_rw           = 1'b1;
    assign qm.m_data         = '0;
    assign qm.m_burst_enable = 1'b1;
    assign qm.m_burst_count  = r_chunk;
    assign qm.m_divider      = DIVIDER;
    assign qm.m_cpol         = CPOL;
    assign qm.m_cpha         = CPHA;
    assign qm.m_mode         = SPI_MODE;

endmodule

// File: tb/tb_qspi_read_streamer.sv
// Bench for qspi_read_streamer: flash-master model, stream scoreboard and a
// burst-plan model computed from request address/length arithmetic.
`timescale 1ns/1ps
module tb_qspi_read_streamer;
    import qspi_read_streamer_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [23:0] req_addr = '0;
    logic [15:0] req_words = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        rd_busy;
    logic        rd_done;
    logic        rd_err;

    always #5 clk = ~clk;

    qspi_read_streamer_if bus ();

    qspi_read_streamer #(
        .FIFO_DEPTH (16),
        .MAX_BURST  (8),
        .READ_CMD   (8'hEB),
        .DIVIDER    (16'd4),
        .SPI_MODE   (2'b10),
        .CPOL       (1'b0),
        .CPHA       (1'b0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_words (req_words),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .rd_busy   (rd_busy),
        .rd_done   (rd_done),
        .rd_err    (rd_err),
        .qm        (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [23:0] a);
        return {a[7:0] ^ 8'hC3, a};
    endfunction

    // ---------------- flash master model ----------------
    logic [23:0] burst_addr_q[$];
    int          burst_cnt_q[$];
    bit          short_next = 1'b0;
    int          enable_cycles = 0;
    int          done_cnt = 0;

    task automatic mstep(inout bit ab);
        @(negedge clk);
        if (reset) ab = 1'b1;
    endtask

    initial begin : master_model
        logic [23:0] ba;
        int          bc;
        int          nb;
        bit          ab;
        bus.m_busy = 1'b0;
        bus.m_done = 1'b0;
        bus.m_burst_read_data_valid = 1'b0;
        bus.m_read_word = '0;
        forever begin
            @(negedge clk);
            if (!reset && bus.m_enable) begin
                ba = bus.m_addr;
                bc = int'(bus.m_burst_count);
                burst_addr_q.push_back(ba);
                burst_cnt_q.push_back(bc);
                nb = short_next ? bc - 1 : bc;
                short_next = 1'b0;
                ab = 1'b0;
                bus.m_busy = 1'b1;
                for (int i = 0; i < nb && !ab; i++) begin
                    int gap;
                    gap = $urandom_range(0, 2);
                    for (int g = 0; g < gap && !ab; g++) begin
                        mstep(ab);
                        bus.m_burst_read_data_valid = 1'b0;
                    end
                    if (!ab) begin
                        mstep(ab);
                        bus.m_burst_read_data_valid = !ab;
                        bus.m_read_word = word_at(ba + 24'(4 * i));
                    end
                end
                if (!ab) begin
                    mstep(ab);
                    bus.m_burst_read_data_valid = 1'b0;
                    bus.m_done = !ab;
                    mstep(ab);
                end
                bus.m_done = 1'b0;
                bus.m_burst_read_data_valid = 1'b0;
                bus.m_busy = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && bus.m_enable) enable_cycles++;
        if (!reset && rd_done) done_cnt++;
    end

    // ---------------- stream consumer / scoreboard ----------------
    logic [31:0] exp_q[$];
    int          ready_mode = 1;
    int          credits = 0;

    always @(negedge clk) begin
        if (reset) begin
            out_ready = 1'b0;
        end else begin
            case (ready_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                2:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = (credits > 0);
            endcase
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL stream_extra: actual=%0h required=no_word", out_data);
                end else begin
                    check("stream_word", out_data, exp_q.pop_front());
                end
                if (ready_mode == 3) credits--;
            end
        end
    end

    // ---------------- reset-state table ----------------
    typedef struct {
        string       name;
        int          idx;
        logic [31:0] exp;
    } rst_vec_t;

    function automatic logic [31:0] probe(input int idx);
        case (idx)
            0:  return 32'(req_ready);
            1:  return 32'(out_valid);
            2:  return out_data;
            3:  return 32'(rd_busy);
            4:  return 32'(rd_done);
            5:  return 32'(rd_err);
            6:  return 32'(bus.m_enable);
            7:  return 32'(bus.m_addr);
            8:  return 32'(bus.m_burst_count);
            9:  return 32'(bus.m_command);
            10: return 32'(bus.m_rw);
            11: return 32'(bus.m_burst_enable);
            12: return bus.m_data;
            13: return 32'(bus.m_divider);
            14: return 32'(bus.m_mode);
            15: return 32'({bus.m_cpol, bus.m_cpha});
            default: return 'x;
        endcase
    endfunction

    // ---------------- request driver ----------------
    task automatic send_req(input logic [23:0] a, input logic [15:0] w);
        int t;
        t = 0;
        @(negedge clk);
        req_addr = a;
        req_words = w;
        req_valid = 1'b1;
        while (!req_ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("req_accept", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_done_drain(input int d0, input string tag);
        int t;
        t = 0;
        while (done_cnt == d0 && t < 4000) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_done_seen"}, 32'(done_cnt != d0), 32'd1);
        t = 0;
        while ((exp_q.size() != 0 || out_valid) && t < 4000) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
        repeat (5) @(negedge clk);
        check({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
    endtask

    task automatic run_req(input string tag, input logic [23:0] a, input logic [15:0] w,
                           input int mode, input int nb_exp, input bit short_b,
                           input bit exp_err, input logic [23:0] second_addr);
        logic [23:0] ea[$];
        int          ec[$];
        logic [23:0] pa;
        int          rem;
        int          d0;
        int          e0;
        int          nw;
        rem = int'(w);
        pa = a;
        while (rem > 0) begin
            int c;
            c = (rem > 8) ? 8 : rem;
            ea.push_back(pa);
            ec.push_back(c);
            pa = pa + 24'(4 * c);
            rem -= c;
        end
        nw = short_b ? int'(w) - 1 : int'(w);
        for (int k = 0; k < nw; k++) exp_q.push_back(word_at(a + 24'(4 * k)));
        burst_addr_q.delete();
        burst_cnt_q.delete();
        ready_mode = mode;
        short_next = short_b;
        d0 = done_cnt;
        e0 = enable_cycles;
        send_req(a, w);
        check({tag, "_err_clear"}, 32'(rd_err), 32'd0);
        if (w == 16'd0) begin
            check({tag, "_zero_done_now"}, 32'(rd_done), 32'd1);
            check({tag, "_zero_idle"}, 32'(req_ready), 32'd1);
            @(negedge clk);
            check({tag, "_zero_done_low"}, 32'(rd_done), 32'd0);
        end
        wait_done_drain(d0, tag);
        check({tag, "_nbursts"}, 32'(burst_addr_q.size()), 32'(nb_exp));
        check({tag, "_enables"}, 32'(enable_cycles - e0), 32'(ea.size()));
        for (int b = 0; b < ea.size() && b < burst_addr_q.size(); b++) begin
            check({tag, "_burst_addr"}, 32'(burst_addr_q[b]), 32'(ea[b]));
            check({tag, "_burst_cnt"}, 32'(burst_cnt_q[b]), 32'(ec[b]));
        end
        if (burst_addr_q.size() > 1) check({tag, "_second_addr"}, 32'(burst_addr_q[1]), 32'(second_addr));
        check({tag, "_err"}, 32'(rd_err), 32'(exp_err));
        check({tag, "_idle"}, 32'(rd_busy), 32'd0);
    endtask

    typedef struct {
        string       tag;
        logic [23:0] addr;
        logic [15:0] words;
        int          mode;
        int          nb_exp;
        bit          short_b;
        bit          exp_err;
        logic [23:0] second_addr;
    } vec_t;

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        rst_vec_t rv[16];
        vec_t     vt[6];
        int       d0;
        int       t;

        rv[0]  = '{"rst_req_ready", 0, 32'd1};
        rv[1]  = '{"rst_out_valid", 1, 32'd0};
        rv[2]  = '{"rst_out_data", 2, 32'd0};
        rv[3]  = '{"rst_rd_busy", 3, 32'd0};
        rv[4]  = '{"rst_rd_done", 4, 32'd0};
        rv[5]  = '{"rst_rd_err", 5, 32'd0};
        rv[6]  = '{"rst_m_enable", 6, 32'd0};
        rv[7]  = '{"rst_m_addr", 7, 32'd0};
        rv[8]  = '{"rst_m_burst_count", 8, 32'd0};
        rv[9]  = '{"rst_m_command", 9, 32'hEB};
        rv[10] = '{"rst_m_rw", 10, 32'd1};
        rv[11] = '{"rst_m_burst_enable", 11, 32'd1};
        rv[12] = '{"rst_m_data", 12, 32'd0};
        rv[13] = '{"rst_m_divider", 13, 32'd4};
        rv[14] = '{"rst_m_mode", 14, 32'd2};
        rv[15] = '{"rst_m_cpol_cpha", 15, 32'd0};

        vt[0] = '{"burst_8_8_4", 24'h000100, 16'd20, 1, 3, 1'b0, 1'b0, 24'h000120};
        vt[1] = '{"addr_wrap",   24'hFFFFF8, 16'd16, 1, 2, 1'b0, 1'b0, 24'h000018};
        vt[2] = '{"zero_words",  24'h000000, 16'd0,  1, 0, 1'b0, 1'b0, 24'h000000};
        vt[3] = '{"short_burst", 24'h000200, 16'd8,  1, 1, 1'b1, 1'b1, 24'h000000};
        vt[4] = '{"after_err",   24'h0003F0, 16'd9,  2, 2, 1'b0, 1'b0, 24'h000410};
        vt[5] = '{"single_word", 24'h123456, 16'd1,  2, 1, 1'b0, 1'b0, 24'h000000};

        reset = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 16; i++) check(rv[i].name, probe(rv[i].idx), rv[i].exp);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_req(vt[i].tag, vt[i].addr, vt[i].words, vt[i].mode, vt[i].nb_exp,
                    vt[i].short_b, vt[i].exp_err, vt[i].second_addr);
        end

        // Backpressure: FIFO fills after two bursts, third waits for 4 pops.
        burst_addr_q.delete();
        burst_cnt_q.delete();
        for (int k = 0; k < 20; k++) exp_q.push_back(word_at(24'h000100 + 24'(4 * k)));
        ready_mode = 0;
        d0 = done_cnt;
        send_req(24'h000100, 16'd20);
        repeat (200) @(negedge clk);
        check("bp_two_bursts", 32'(burst_addr_q.size()), 32'd2);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        credits = 3;
        ready_mode = 3;
        repeat (100) @(negedge clk);
        check("bp_still_two", 32'(burst_addr_q.size()), 32'd2);
        check("bp_popped_three", 32'(exp_q.size()), 32'd17);
        credits = 1;
        repeat (100) @(negedge clk);
        check("bp_third_issued", 32'(burst_addr_q.size()), 32'd3);
        if (burst_addr_q.size() == 3) begin
            check("bp_third_addr", 32'(burst_addr_q[2]), 32'h000140);
            check("bp_third_cnt", 32'(burst_cnt_q[2]), 32'd4);
        end
        ready_mode = 1;
        wait_done_drain(d0, "bp");

        // Reset in the middle of a burst.
        ready_mode = 0;
        for (int k = 0; k < 20; k++) exp_q.push_back(word_at(24'h000400 + 24'(4 * k)));
        send_req(24'h000400, 16'd20);
        t = 0;
        while (!out_valid && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("mid_first_word", 32'(out_valid), 32'd1);
        check("mid_in_xfer", 32'(rd_busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 7; i++) check({"mid_", rv[i].name}, probe(rv[i].idx), rv[i].exp);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk);

        // Randomized requests against the burst-plan model.
        for (int r = 0; r < 6; r++) begin
            logic [23:0] ra;
            logic [15:0] rw;
            ra = 24'($urandom);
            rw = 16'($urandom_range(1, 40));
            run_req($sformatf("rand%0d", r), ra, rw, 2, (int'(rw) + 7) / 8, 1'b0, 1'b0, ra + 24'd32);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
